// File: rtl/gray_bcd_pkg.sv
// Shared types and helpers for the Gray/binary-to-BCD converter.
// Also holds the digit-count helper used by the elaboration-time width check.
package gray_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } gb_state_t;

  // Fewest decimal digits needed to represent 2**w-1
  function automatic int bcd_digits(int w);
    longint unsigned m;
    int d;
    m = (longint'(1) << w) - 1;
    d = 1;
    while (m > 9) begin
      m = m / 10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/gray_bcd_seq_if.sv
// Valid/ready bundle between the code source, the converter and the display.
// The master side feeds codes and accepts results; the slave is the converter.
interface gray_bcd_seq_if #(
  parameter int GRAY_W = 8,
  parameter int DIGITS = 3
);

  logic              in_valid;
  logic              in_ready;
  logic [GRAY_W-1:0] code_in;
  logic              bin_mode;
  logic              out_valid;
  logic              out_ready;
  logic [4*DIGITS-1:0] bcd_out;
  logic              busy;

  modport master (
    output in_valid,
    output code_in,
    output bin_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  bcd_out,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  code_in,
    input  bin_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output bcd_out,
    output busy
  );

endinterface

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decode.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
  parameter int W = 8
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/gray_bcd_seq.sv
// Multi-cycle double-dabble converter: Gray or binary code in, packed BCD out.
// One input bit is consumed per SHIFT cycle; the result is held until taken.
module gray_bcd_seq
  import gray_bcd_pkg::*;
#(
  parameter int GRAY_W = 8,
  parameter int DIGITS = 3
) (
  input  logic clk,
  input  logic rst,
  gray_bcd_seq_if.slave bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(GRAY_W + 1);

  if (GRAY_W < 2) begin : g_wchk
    $error("gray_bcd_seq: GRAY_W must be at least 2");
  end
  if (DIGITS < bcd_digits(GRAY_W)) begin : g_dchk
    $error("gray_bcd_seq: DIGITS too small for GRAY_W");
  end

  gb_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GRAY_W-1:0] bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BW-1:0]     out_q, out_d;

  logic [GRAY_W-1:0]    bin_g;
  logic [BW-1:0]        adj;
  logic [BW+GRAY_W-1:0] sh;
  logic                 in_rdy, out_vld, busy;

  gray_to_bin #(.W(GRAY_W)) u_g2b (
    .gray_i(bus.code_in),
    .bin_o (bin_g)
  );

  // Add-3 correction: each digit >=5 gets +3, no carry between digits
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Next-state, datapath update and handshake outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    out_d   = out_q;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    busy    = 1'b0;
    sh      = {adj, bin_q} << 1;
    unique case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (bus.in_valid) begin
          bin_d   = bus.bin_mode ? bus.code_in : bin_g;
          bcd_d   = '0;
          cnt_d   = CW'(GRAY_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy  = 1'b1;
        bcd_d = sh[BW+GRAY_W-1:GRAY_W];
        bin_d = sh[GRAY_W-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          out_d   = sh[BW+GRAY_W-1:GRAY_W];
          state_d = DONE;
        end
      end
      DONE: begin
        out_vld = 1'b1;
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      out_q   <= out_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.busy      = busy;
  assign bus.bcd_out   = out_q;

endmodule

// File: tb/tb_gray_bcd_seq.sv
// Directed bench for gray_bcd_seq: an 8-bit/3-digit instance
// and a 4-bit/2-digit instance swept over all Gray codes.
module tb_gray_bcd_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  gray_bcd_seq_if #(.GRAY_W(8), .DIGITS(3)) bus8 ();
  gray_bcd_seq_if #(.GRAY_W(4), .DIGITS(2)) bus4 ();

  gray_bcd_seq #(.GRAY_W(8), .DIGITS(3)) u_dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8.slave)
  );

  gray_bcd_seq #(.GRAY_W(4), .DIGITS(2)) u_dut4 (
    .clk(clk),
    .rst(rst),
    .bus(bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_checks(input string name, input logic [11:0] exp_bcd);
    checks++;
    if (bus8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready: got %b want 1", name, bus8.in_ready);
    end
    checks++;
    if (bus8.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s out_valid: got %b want 0", name, bus8.out_valid);
    end
    checks++;
    if (bus8.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: got %b want 0", name, bus8.busy);
    end
    checks++;
    if (bus8.bcd_out !== exp_bcd) begin
      errors++;
      $display("FAIL %s bcd_out: got %h want %h", name, bus8.bcd_out, exp_bcd);
    end
  endtask

  task automatic run8(input logic [7:0] code, input logic mode,
                      input logic [11:0] exp, input string name);
    int n;
    bus8.code_in  = code;
    bus8.bin_mode = mode;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    n = 0;
    while (bus8.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL %s latency: got %0d want 8", name, n);
    end
    checks++;
    if (bus8.bcd_out !== exp) begin
      errors++;
      $display("FAIL %s bcd_out: got %h want %h", name, bus8.bcd_out, exp);
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    checks++;
    if (bus8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s back_idle: got %b want 1", name, bus8.in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    idle_checks("reset_init", 12'h000);
    @(negedge clk);
    rst = 1'b0;
    run8(8'h0A, 1'b0, 12'h012, "pre_reset");
    bus8.code_in  = 8'h80;
    bus8.bin_mode = 1'b0;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    idle_checks("reset_async", 12'h000);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_gray;
    run8(8'b0000_1010, 1'b0, 12'h012, "gray_12");
  endtask

  task automatic test_gray_bounds;
    run8(8'b1000_0000, 1'b0, 12'h255, "gray_max");
    run8(8'h00, 1'b0, 12'h000, "gray_zero");
    run8(8'hFF, 1'b1, 12'h255, "bin_max");
  endtask

  task automatic test_binary;
    run8(8'd200, 1'b1, 12'h200, "bin_200");
    run8(8'd200, 1'b0, 12'h143, "gray_200");
  endtask

  task automatic test_backpressure;
    int n;
    bus8.code_in  = 8'b0000_1010;
    bus8.bin_mode = 1'b0;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (bus8.out_valid !== 1'b1 && n < 40) begin
      bus8.code_in  = 8'($urandom);
      bus8.bin_mode = ~bus8.bin_mode;
      @(posedge clk); #1;
      n++;
    end
    bus8.in_valid = 1'b0;
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL bp latency: got %0d want 8", n);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus8.bcd_out !== 12'h012 || bus8.out_valid !== 1'b1 ||
          bus8.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got bcd=%h ov=%b ir=%b want 012 1 0",
                 i, bus8.bcd_out, bus8.out_valid, bus8.in_ready);
      end
      @(posedge clk); #1;
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    idle_checks("bp_release", 12'h012);
  endtask

  task automatic test_reset_mid_shift;
    bus8.code_in  = 8'hC8;
    bus8.bin_mode = 1'b1;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus8.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got %b want 1", bus8.busy);
    end
    rst = 1'b1;
    #1;
    idle_checks("mid_reset", 12'h000);
    @(posedge clk); #1;
    rst = 1'b0;
    run8(8'd99, 1'b1, 12'h099, "after_reset_99");
  endtask

  task automatic test_small_sweep;
    logic [3:0] b;
    logic       acc;
    logic [7:0] exp;
    int         n;
    for (int g = 0; g < 16; g++) begin
      acc = 1'b0;
      for (int i = 3; i >= 0; i--) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
      exp = {4'(b / 10), 4'(b % 10)};
      bus4.code_in  = 4'(g);
      bus4.bin_mode = 1'b0;
      bus4.in_valid = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      n = 0;
      while (bus4.out_valid !== 1'b1 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      checks++;
      if (n != 4 || bus4.bcd_out !== exp) begin
        errors++;
        $display("FAIL w4_gray%0d: got bcd=%h lat=%0d want %h lat=4",
                 g, bus4.bcd_out, n, exp);
      end
      bus4.out_ready = 1'b1;
      @(posedge clk); #1;
      bus4.out_ready = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.code_in   = '0;
    bus8.bin_mode  = 1'b0;
    bus8.out_ready = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.code_in   = '0;
    bus4.bin_mode  = 1'b0;
    bus4.out_ready = 1'b0;
    test_reset;
    test_gray;
    test_gray_bounds;
    test_binary;
    test_backpressure;
    test_reset_mid_shift;
    test_small_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
